mips_multi_control: RTL and testbench

- Main control FSM for the multicycle MIPS core.
- Sequences one shared datapath: unified instruction/data memory, IR, register file, ALU with 3-bit `select`, PC.
- Each state drives Moore-style mux selects, write enables and the ALU `select` code. The PC enable also uses the ALU `zero` flag in the branch state.
- Sits between the instruction register (opcode/funct fields) and the datapath muxes.

---
 rtl/mips_multi_control.sv | 171 +++++++++++++++++
 tb/tb_mips_multi_control.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mips_multi_control.sv
// rtl/mips_multi_control.sv - main control FSM for the multicycle MIPS core
module mips_multi_control #(
    parameter int OPW = 6,
    parameter int FNW = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic [FNW-1:0] funct,
    input  logic           zero,
    output logic           pc_en,
    output logic           i_or_d,
    output logic           mem_write,
    output logic           ir_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           reg_write,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic           ext_sel,
    output logic [1:0]     pc_source,
    output logic [2:0]     alu_select,
    output logic           illegal,
    output logic [3:0]     state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEM_ADR = 4'd2,
        MEM_RD  = 4'd3,
        MEM_WB  = 4'd4,
        MEM_WR  = 4'd5,
        EXEC    = 4'd6,
        ALU_WB  = 4'd7,
        BRANCH  = 4'd8,
        IMM_EXE = 4'd9,
        IMM_WB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'h00);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'h02);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'h04);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6'h05);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'h08);
    localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'h0C);
    localparam logic [OPW-1:0] OP_ORI   = OPW'(6'h0D);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'h23);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'h2B);

    localparam logic [FNW-1:0] FN_ADD = FNW'(6'h20);
    localparam logic [FNW-1:0] FN_SUB = FNW'(6'h22);
    localparam logic [FNW-1:0] FN_AND = FNW'(6'h24);
    localparam logic [FNW-1:0] FN_OR  = FNW'(6'h25);
    localparam logic [FNW-1:0] FN_XOR = FNW'(6'h26);

    state_t state_q, state_d;
    logic   funct_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    assign state    = state_q;
    assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                      (funct == FN_OR)  || (funct == FN_XOR);

    // Outputs are held at zero while reset is low, even though state already reads FETCH.
    always_comb begin
        state_d    = FETCH;
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_sel    = 1'b0;
        pc_source  = 2'b00;
        alu_select = 3'b000;
        illegal    = 1'b0;
        if (reset) begin
            case (state_q)
                FETCH: begin
                    ir_write  = 1'b1;
                    alu_src_b = 2'b01;
                    pc_en     = 1'b1;
                    state_d   = DECODE;
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    if (opcode == OP_LW || opcode == OP_SW)
                        state_d = MEM_ADR;
                    else if (opcode == OP_RTYPE && funct_ok)
                        state_d = EXEC;
                    else if (opcode == OP_BEQ || opcode == OP_BNE)
                        state_d = BRANCH;
                    else if (opcode == OP_ADDI || opcode == OP_ANDI || opcode == OP_ORI)
                        state_d = IMM_EXE;
                    else if (opcode == OP_J)
                        state_d = JUMP;
                    else
                        illegal = 1'b1;
                end
                MEM_ADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = (opcode == OP_SW) ? MEM_WR : MEM_RD;
                end
                MEM_RD: begin
                    i_or_d  = 1'b1;
                    state_d = MEM_WB;
                end
                MEM_WB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                MEM_WR: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    case (funct)
                        FN_SUB:  alu_select = 3'b001;
                        FN_AND:  alu_select = 3'b010;
                        FN_OR:   alu_select = 3'b011;
                        FN_XOR:  alu_select = 3'b110;
                        default: alu_select = 3'b000;
                    endcase
                    state_d = ALU_WB;
                end
                ALU_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_select = 3'b001;
                    pc_source  = 2'b01;
                    pc_en      = (opcode == OP_BNE) ? ~zero : zero;
                end
                IMM_EXE: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    if (opcode == OP_ANDI) begin
                        ext_sel    = 1'b1;
                        alu_select = 3'b010;
                    end else if (opcode == OP_ORI) begin
                        ext_sel    = 1'b1;
                        alu_select = 3'b011;
                    end
                    state_d = IMM_WB;
                end
                IMM_WB: begin
                    reg_write = 1'b1;
                end
                JUMP: begin
                    pc_source = 2'b10;
                    pc_en     = 1'b1;
                end
                default: state_d = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multi_control.sv
// tb/tb_mips_multi_control.sv - directed self-checking bench for mips_multi_control
module tb_mips_multi_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic       ext_sel, illegal;
    logic [2:0] alu_select;
    logic [3:0] state;
    logic [16:0] outv;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_multi_control #(.OPW(6), .FNW(6)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en), .i_or_d(i_or_d), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_sel(ext_sel),
        .pc_source(pc_source), .alu_select(alu_select), .illegal(illegal), .state(state)
    );

    // {pc_en,i_or_d,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,ext_sel,pc_source,alu_select,illegal}
    assign outv = {pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                   alu_src_a, alu_src_b, ext_sel, pc_source, alu_select, illegal};

    localparam logic [16:0] O_ZERO   = 17'b0_0_0_0_0_0_0_0_00_0_00_000_0;
    localparam logic [16:0] O_FETCH  = 17'b1_0_0_1_0_0_0_0_01_0_00_000_0;
    localparam logic [16:0] O_DEC    = 17'b0_0_0_0_0_0_0_0_11_0_00_000_0;
    localparam logic [16:0] O_DECILL = 17'b0_0_0_0_0_0_0_0_11_0_00_000_1;
    localparam logic [16:0] O_MADR   = 17'b0_0_0_0_0_0_0_1_10_0_00_000_0;
    localparam logic [16:0] O_MRD    = 17'b0_1_0_0_0_0_0_0_00_0_00_000_0;
    localparam logic [16:0] O_MWB    = 17'b0_0_0_0_0_1_1_0_00_0_00_000_0;
    localparam logic [16:0] O_MWR    = 17'b0_1_1_0_0_0_0_0_00_0_00_000_0;
    localparam logic [16:0] O_EXSUB  = 17'b0_0_0_0_0_0_0_1_00_0_00_001_0;
    localparam logic [16:0] O_EXXOR  = 17'b0_0_0_0_0_0_0_1_00_0_00_110_0;
    localparam logic [16:0] O_ALUWB  = 17'b0_0_0_0_1_0_1_0_00_0_00_000_0;
    localparam logic [16:0] O_BR_T   = 17'b1_0_0_0_0_0_0_1_00_0_01_001_0;
    localparam logic [16:0] O_BR_N   = 17'b0_0_0_0_0_0_0_1_00_0_01_001_0;
    localparam logic [16:0] O_ORI    = 17'b0_0_0_0_0_0_0_1_10_1_00_011_0;
    localparam logic [16:0] O_ANDI   = 17'b0_0_0_0_0_0_0_1_10_1_00_010_0;
    localparam logic [16:0] O_IMMWB  = 17'b0_0_0_0_0_0_1_0_00_0_00_000_0;
    localparam logic [16:0] O_JUMP   = 17'b1_0_0_0_0_0_0_0_00_0_10_000_0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] st, input logic [16:0] ov);
        check({tag, "_st"}, 32'(state), 32'(st));
        check({tag, "_out"}, 32'(outv), 32'(ov));
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        opcode = op;
        funct  = fn;
        zero   = z;
    endtask

    initial begin
        reset = 1'b0;
        instr(6'h00, 6'h00, 1'b0);
        #12;
        check("rst_st", 32'(state), 0);
        check("rst_out", 32'(outv), 32'(O_ZERO));
        @(negedge clk);
        reset = 1'b1;
        #1;

        instr(6'h23, 6'h00, 1'b0);
        cyc("lw0", 4'd0, O_FETCH);
        cyc("lw1", 4'd1, O_DEC);
        cyc("lw2", 4'd2, O_MADR);
        cyc("lw3", 4'd3, O_MRD);
        cyc("lw4", 4'd4, O_MWB);

        instr(6'h2B, 6'h00, 1'b0);
        cyc("sw0", 4'd0, O_FETCH);
        cyc("sw1", 4'd1, O_DEC);
        cyc("sw2", 4'd2, O_MADR);
        cyc("sw3", 4'd5, O_MWR);

        instr(6'h00, 6'h22, 1'b0);
        cyc("sub0", 4'd0, O_FETCH);
        cyc("sub1", 4'd1, O_DEC);
        cyc("sub2", 4'd6, O_EXSUB);
        cyc("sub3", 4'd7, O_ALUWB);

        instr(6'h00, 6'h26, 1'b0);
        cyc("xor0", 4'd0, O_FETCH);
        cyc("xor1", 4'd1, O_DEC);
        cyc("xor2", 4'd6, O_EXXOR);
        cyc("xor3", 4'd7, O_ALUWB);

        instr(6'h04, 6'h00, 1'b1);
        cyc("beqt0", 4'd0, O_FETCH);
        cyc("beqt1", 4'd1, O_DEC);
        cyc("beqt2", 4'd8, O_BR_T);

        instr(6'h04, 6'h00, 1'b0);
        cyc("beqn0", 4'd0, O_FETCH);
        cyc("beqn1", 4'd1, O_DEC);
        cyc("beqn2", 4'd8, O_BR_N);

        instr(6'h05, 6'h00, 1'b0);
        cyc("bne0", 4'd0, O_FETCH);
        cyc("bne1", 4'd1, O_DEC);
        cyc("bne2", 4'd8, O_BR_T);

        instr(6'h0D, 6'h00, 1'b0);
        cyc("ori0", 4'd0, O_FETCH);
        cyc("ori1", 4'd1, O_DEC);
        cyc("ori2", 4'd9, O_ORI);
        cyc("ori3", 4'd10, O_IMMWB);

        instr(6'h0C, 6'h00, 1'b0);
        cyc("andi0", 4'd0, O_FETCH);
        cyc("andi1", 4'd1, O_DEC);
        cyc("andi2", 4'd9, O_ANDI);
        cyc("andi3", 4'd10, O_IMMWB);

        instr(6'h02, 6'h00, 1'b0);
        cyc("j0", 4'd0, O_FETCH);
        cyc("j1", 4'd1, O_DEC);
        cyc("j2", 4'd11, O_JUMP);

        instr(6'h3F, 6'h00, 1'b0);
        cyc("ill0", 4'd0, O_FETCH);
        cyc("ill1", 4'd1, O_DECILL);

        instr(6'h00, 6'h2A, 1'b0);
        cyc("slt0", 4'd0, O_FETCH);
        cyc("slt1", 4'd1, O_DECILL);

        instr(6'h00, 6'h20, 1'b0);
        cyc("add0", 4'd0, O_FETCH);
        cyc("add1", 4'd1, O_DEC);
        check("add2_st", 32'(state), 6);
        reset = 1'b0;
        #1;
        check("arst_st", 32'(state), 0);
        check("arst_out", 32'(outv), 32'(O_ZERO));
        @(posedge clk);
        #1;
        check("arst_hold_st", 32'(state), 0);
        check("arst_hold_rw", 32'(reg_write), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        cyc("rel0", 4'd0, O_FETCH);
        cyc("rel1", 4'd1, O_DEC);
        cyc("rel2", 4'd6, 17'b0_0_0_0_0_0_0_1_00_0_00_000_0);
        cyc("rel3", 4'd7, O_ALUWB);
        check("end_st", 32'(state), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
